ace_ccu_excl_monitor: RTL
=========================

// Module: ace_ccu_excl_monitor
// PURPOSE
//  Exclusive-access monitor for the CCU. It is fed by the master path's
//  exclusive-load/-store requests and by line clears from the snoop
//  interconnect. It returns the EXOKAY/OKAY decision for each exclusive
//  store. It holds one cache-line reservation per exclusive requester.
// PARAMETERS
//  AxiAddrWidth  64  address width
//  NumMasters    4   reservation holders (= 2*NoGroups in CCU)
//  AmAddrBase    6   line offset bits; line tag = addr[AxiAddrWidth-1:AmAddrBase]
//  IdWidth       $clog2(NumMasters) (min 1)  requester index width
// PORTS
//  clk_i          in   1             clock
//  rst_ni         in   1             async reset, active low
//  ld_valid_i     in   1             exclusive load observed
//  ld_ready_o     out  1             load accepted
//  ld_id_i        in   IdWidth       requester of load
//  ld_addr_i      in   AxiAddrWidth  load address
//  st_valid_i     in   1             exclusive store to decide
//  st_ready_o     out  1             store accepted
//  st_id_i        in   IdWidth       requester of store
//  st_addr_i      in   AxiAddrWidth  store address
//  clr_valid_i    in   1             non-excl write/invalidating snoop; always accepted
//  clr_addr_i     in   AxiAddrWidth  line to clear
//  resp_valid_o   out  1             decision valid
//  resp_ready_i   in   1             decision consumed
//  resp_id_o      out  IdWidth       requester of decided store
//  resp_exokay_o  out  1             1 = EXOKAY (success), 0 = OKAY (fail)
// BEHAVIOUR
//  - State: per master {rsv_vld, rsv_tag}; output register {resp_valid, id, exokay}.
//  - Reset: all rsv_vld=0, resp_valid_o=0, resp_id_o=0, resp_exokay_o=0.
//    Reset mid-transfer drops the pending response and all reservations.
//  - FSM: IDLE (resp_valid_o=0) / RESP (resp_valid_o=1).
//    RESP->IDLE on resp_ready_i with no new store.
//    Store handshake in either state -> RESP next cycle.
//  - st_ready_o = !resp_valid_o | resp_ready_i (back-to-back stores at 1/cycle).
//  - ld_ready_o = !(st_valid_i & st_ready_o): at most one of load/store per cycle;
//    store has priority.
//  - Per-cycle update order: (1) clr, (2) store, (3) load. Store and load see
//    the result of the earlier steps.
//    (1) clr_valid_i: rsv_vld[m]=0 for every m whose tag equals the clr line.
//    (2) store handshake: exokay = rsv_vld[id] & (rsv_tag[id]==st line).
//        On success, clear all reservations with that tag (incl. own).
//        On fail, clear own reservation.
//        Decision is registered; latency 1 cycle handshake->resp_valid_o.
//    (3) load handshake: rsv_vld[id]=1, rsv_tag[id]=ld line. Overwrites any
//        previous reservation. A load survives a same-cycle clr of the same line.
//  - Response outputs stay stable while resp_valid_o & !resp_ready_i.
//  - id >= NumMasters (non-power-of-two NumMasters):
//    load is ignored but still accepted; store is accepted and fails.
//  - Tags compare full line address; no aliasing, no false success.
// CONFIGURATION
//  ACE_CCU_EXCL_STATS_EN defined: extra outputs succ_cnt_o[15:0], fail_cnt_o[15:0].
//    Each increments on a registered decision (exokay 1 / 0).
//    Saturates at 16'hFFFF; reset to 0.
//  Undefined: ports and counters absent; behaviour otherwise identical.
// TESTING
//  1 ld id1 0x1040; st id1 0x1078 (same 64B line) -> next cycle resp id1
//    exokay=1. Repeat st id1 0x1040 -> exokay=0.
//  2 ld id0 0x2000, ld id2 0x2000; st id2 0x2000 -> exokay=1;
//    st id0 0x2000 -> exokay=0 (cleared by peer success).
//  3 ld id3 0x3000; clr 0x3020; st id3 0x3000 -> exokay=0.
//    ld id3 and clr 0x3000 in the same cycle; st id3 0x3000 -> exokay=1.
//  4 st id1 with resp_ready_i=0 for 5 cycles -> resp_valid_o/id/exokay held,
//    st_ready_o=0, ld_ready_o=1. On ready, a second store is accepted the same
//    cycle -> its resp in the next cycle.
//  5 ld id2 0x4000, assert rst_ni=0 one cycle while resp pending ->
//    resp_valid_o=0 immediately; st id2 0x4000 afterwards -> exokay=0.
//  6 STATS_EN: 3 successes + 2 fails -> succ=3, fail=2.
//    Preload succ=16'hFFFF and succeed -> stays 16'hFFFF.

Source files
------------

// File: rtl/ace_ccu_excl_monitor.sv
// Exclusive-access monitor: one cache-line reservation per requester, EXOKAY/OKAY decision per exclusive store.
// Optional decision counters enabled by defining ACE_CCU_EXCL_STATS_EN.
//
// state | meaning
// IDLE  | no decision pending, resp_valid_o=0
// RESP  | registered decision presented, resp_valid_o=1
module ace_ccu_excl_monitor #(
  parameter int unsigned AxiAddrWidth = 64,
  parameter int unsigned NumMasters   = 4,
  parameter int unsigned AmAddrBase   = 6,
  parameter int unsigned IdWidth      = (NumMasters > 1) ? $clog2(NumMasters) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    ld_valid_i,
  output logic                    ld_ready_o,
  input  logic [IdWidth-1:0]      ld_id_i,
  input  logic [AxiAddrWidth-1:0] ld_addr_i,
  input  logic                    st_valid_i,
  output logic                    st_ready_o,
  input  logic [IdWidth-1:0]      st_id_i,
  input  logic [AxiAddrWidth-1:0] st_addr_i,
  input  logic                    clr_valid_i,
  input  logic [AxiAddrWidth-1:0] clr_addr_i,
  output logic                    resp_valid_o,
  input  logic                    resp_ready_i,
  output logic [IdWidth-1:0]      resp_id_o,
  output logic                    resp_exokay_o
`ifdef ACE_CCU_EXCL_STATS_EN
  ,
  output logic [15:0]             succ_cnt_o,
  output logic [15:0]             fail_cnt_o
`endif
);

  localparam int unsigned TagW = AxiAddrWidth - AmAddrBase;

  typedef enum logic {IDLE, RESP} state_e;

  state_e                state_q, state_d;
  logic [NumMasters-1:0] vld_q, vld_d;
  logic [TagW-1:0]       tag_q [NumMasters];
  logic [TagW-1:0]       tag_d [NumMasters];
  logic [TagW-1:0]       ld_tag, st_tag, clr_tag;
  logic                  st_hs, ld_hs, st_ok;
  logic [IdWidth-1:0]    id_q;
  logic                  exokay_q;

  assign ld_tag  = ld_addr_i[AxiAddrWidth-1:AmAddrBase];
  assign st_tag  = st_addr_i[AxiAddrWidth-1:AmAddrBase];
  assign clr_tag = clr_addr_i[AxiAddrWidth-1:AmAddrBase];

  assign resp_valid_o  = (state_q == RESP);
  assign resp_id_o     = id_q;
  assign resp_exokay_o = exokay_q;
  assign st_ready_o    = !resp_valid_o | resp_ready_i;
  assign ld_ready_o    = !(st_valid_i & st_ready_o);
  assign st_hs         = st_valid_i & st_ready_o;
  assign ld_hs         = ld_valid_i & ld_ready_o;

  // Clear, then store, then load; each step sees the previous one's result.
  // Ids beyond NumMasters match no slot, so their loads vanish and stores fail.
  always_comb begin
    vld_d = vld_q;
    tag_d = tag_q;
    st_ok = 1'b0;
    for (int m = 0; m < NumMasters; m++) begin
      if (clr_valid_i && tag_q[m] == clr_tag) vld_d[m] = 1'b0;
    end
    for (int m = 0; m < NumMasters; m++) begin
      if (st_id_i == IdWidth'(m) && vld_d[m] && tag_q[m] == st_tag) st_ok = 1'b1;
    end
    if (st_hs) begin
      for (int m = 0; m < NumMasters; m++) begin
        if ((st_ok && tag_q[m] == st_tag) || st_id_i == IdWidth'(m)) vld_d[m] = 1'b0;
      end
    end
    if (ld_hs) begin
      for (int m = 0; m < NumMasters; m++) begin
        if (ld_id_i == IdWidth'(m)) begin
          vld_d[m] = 1'b1;
          tag_d[m] = ld_tag;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    if (st_hs) begin
      state_d = RESP;
    end else if (state_q == RESP && resp_ready_i) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      vld_q    <= '0;
      id_q     <= '0;
      exokay_q <= 1'b0;
      for (int m = 0; m < NumMasters; m++) tag_q[m] <= '0;
    end else begin
      state_q <= state_d;
      vld_q   <= vld_d;
      tag_q   <= tag_d;
      if (st_hs) begin
        id_q     <= st_id_i;
        exokay_q <= st_ok;
      end
    end
  end

`ifdef ACE_CCU_EXCL_STATS_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      succ_cnt_o <= '0;
      fail_cnt_o <= '0;
    end else if (st_hs) begin
      if (st_ok && succ_cnt_o != 16'hFFFF) succ_cnt_o <= succ_cnt_o + 16'd1;
      if (!st_ok && fail_cnt_o != 16'hFFFF) fail_cnt_o <= fail_cnt_o + 16'd1;
    end
  end
`endif

endmodule
